vga_plot_scheduler: RTL and testbench

//  Sits between the control path's VGA driver and the VGA adapter. Queues CPU pixel-plot requests
//  in a small FIFO and sequences a full-screen clear sweep. It issues at most one pixel per cycle
//  to the adapter, and CPU plots and clears never interleave.

---
 rtl/vga_plot_scheduler.sv | 175 +++++++++++++++++
 tb/tb_vga_plot_scheduler.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_plot_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : vga_plot_scheduler
// Description : Queues CPU pixel plots in a small FIFO and sequences full-screen
//               clear sweeps, issuing at most one registered pixel per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module vga_plot_scheduler #(
    parameter int X_WIDTH     = 8,
    parameter int Y_WIDTH     = 7,
    parameter int COLOR_WIDTH = 3,
    parameter int X_MAX       = 160,
    parameter int Y_MAX       = 120,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [X_WIDTH-1:0]     req_x,
    input  logic [Y_WIDTH-1:0]     req_y,
    input  logic [COLOR_WIDTH-1:0] req_color,
    input  logic                   clear_start,
    input  logic [COLOR_WIDTH-1:0] clear_color,
    input  logic                   out_stall,
    output logic [X_WIDTH-1:0]     vga_x,
    output logic [Y_WIDTH-1:0]     vga_y,
    output logic [COLOR_WIDTH-1:0] vga_color,
    output logic                   vga_plot,
    output logic                   range_err,
    output logic                   busy
);

    localparam int                     c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int                     c_ENTRY_W = X_WIDTH + Y_WIDTH + COLOR_WIDTH;
    localparam logic [X_WIDTH:0]       c_X_LIM   = (X_WIDTH+1)'(X_MAX);
    localparam logic [Y_WIDTH:0]       c_Y_LIM   = (Y_WIDTH+1)'(Y_MAX);
    localparam logic [X_WIDTH-1:0]     c_X_LAST  = X_WIDTH'(X_MAX - 1);
    localparam logic [Y_WIDTH-1:0]     c_Y_LAST  = Y_WIDTH'(Y_MAX - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_CLEAR = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;

    logic [c_ENTRY_W-1:0]     r_mem [FIFO_DEPTH];
    logic [c_PTR_W:0]         r_wr_ptr;
    logic [c_PTR_W:0]         r_rd_ptr;
    logic                     r_clear_pend;
    logic [COLOR_WIDTH-1:0]   r_clear_col;
    logic [X_WIDTH-1:0]       r_cx;
    logic [Y_WIDTH-1:0]       r_cy;
    logic [X_WIDTH-1:0]       r_vga_x;
    logic [Y_WIDTH-1:0]       r_vga_y;
    logic [COLOR_WIDTH-1:0]   r_vga_color;
    logic                     r_vga_plot;
    logic                     r_range_err;

    logic                     w_empty;
    logic                     w_full;
    logic                     w_req_ready;
    logic                     w_push;
    logic                     w_pop;
    logic                     w_in_range;
    logic                     w_clear_take;
    logic                     w_clear_emit;
    logic                     w_clear_last;
    logic [c_ENTRY_W-1:0]     w_head;
    logic [X_WIDTH-1:0]       w_head_x;
    logic [Y_WIDTH-1:0]       w_head_y;
    logic [COLOR_WIDTH-1:0]   w_head_color;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                     (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);

    assign w_head = r_mem[r_rd_ptr[c_PTR_W-1:0]];
    assign {w_head_x, w_head_y, w_head_color} = w_head;
    assign w_in_range = ({1'b0, w_head_x} < c_X_LIM) && ({1'b0, w_head_y} < c_Y_LIM);

    assign w_req_ready  = !reset && !w_full && (r_state == S_IDLE) && !r_clear_pend;
    assign w_push       = req_valid && w_req_ready;
    assign w_pop        = ((r_state == S_IDLE) || (r_state == S_DRAIN)) && !w_empty && !out_stall;
    assign w_clear_take = (r_state == S_IDLE) && !r_clear_pend && clear_start;
    assign w_clear_emit = (r_state == S_CLEAR) && !out_stall;
    assign w_clear_last = w_clear_emit && (r_cx == c_X_LAST) && (r_cy == c_Y_LAST);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            // A request accepted alongside clear_start must be drained first.
            S_IDLE:  if (w_clear_take) w_state_nxt = (w_empty && !w_push) ? S_CLEAR : S_DRAIN;
            S_DRAIN: if (w_empty) w_state_nxt = S_CLEAR;
            S_CLEAR: if (w_clear_last) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (w_push) begin
            r_mem[r_wr_ptr[c_PTR_W-1:0]] <= {req_x, req_y, req_color};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_clear_pend <= 1'b0;
            r_clear_col  <= '0;
            r_cx         <= '0;
            r_cy         <= '0;
            r_vga_x      <= '0;
            r_vga_y      <= '0;
            r_vga_color  <= '0;
            r_vga_plot   <= 1'b0;
            r_range_err  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_vga_plot  <= 1'b0;
            r_range_err <= 1'b0;

            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end

            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
                if (w_in_range) begin
                    r_vga_x     <= w_head_x;
                    r_vga_y     <= w_head_y;
                    r_vga_color <= w_head_color;
                    r_vga_plot  <= 1'b1;
                end else begin
                    r_range_err <= 1'b1;
                end
            end else if (w_clear_emit) begin
                r_vga_x     <= r_cx;
                r_vga_y     <= r_cy;
                r_vga_color <= r_clear_col;
                r_vga_plot  <= 1'b1;
                // Raster advance; the final pixel wraps both counters back to 0.
                if (r_cx == c_X_LAST) begin
                    r_cx <= '0;
                    r_cy <= (r_cy == c_Y_LAST) ? '0 : r_cy + 1'b1;
                end else begin
                    r_cx <= r_cx + 1'b1;
                end
            end

            if (w_clear_take) begin
                r_clear_pend <= 1'b1;
                r_clear_col  <= clear_color;
            end else if (w_clear_last) begin
                r_clear_pend <= 1'b0;
            end
        end
    end

    assign req_ready = w_req_ready;
    assign vga_x     = r_vga_x;
    assign vga_y     = r_vga_y;
    assign vga_color = r_vga_color;
    assign vga_plot  = r_vga_plot;
    assign range_err = r_range_err;
    assign busy      = !reset && ((r_state != S_IDLE) || r_clear_pend || !w_empty || r_vga_plot);

endmodule
`default_nettype wire

// File: tb/tb_vga_plot_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_vga_plot_scheduler
// Description : Directed self-checking bench for vga_plot_scheduler.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_vga_plot_scheduler;

    localparam int c_PIXELS = 160 * 120;

    logic       clock;
    logic       reset;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_x;
    logic [6:0] req_y;
    logic [2:0] req_color;
    logic       clear_start;
    logic [2:0] clear_color;
    logic       out_stall;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_color;
    logic       vga_plot;
    logic       range_err;
    logic       busy;

    int n_total;
    int n_bad;

    vga_plot_scheduler dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_x       (req_x),
        .req_y       (req_y),
        .req_color   (req_color),
        .clear_start (clear_start),
        .clear_color (clear_color),
        .out_stall   (out_stall),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_color   (vga_color),
        .vga_plot    (vga_plot),
        .range_err   (range_err),
        .busy        (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #1500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Advance one active edge and settle before sampling.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_req(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        req_valid = 1'b1;
        req_x     = x;
        req_y     = y;
        req_color = c;
    endtask

    // Collect plots of a clear sweep, optionally preceded by the two queued
    // entries (10,20,1) and (11,21,2); rnd adds random stalls and a second clear_start.
    task automatic run_clear(input string tag, input int pre, input logic [2:0] col, input bit rnd);
        int         got;
        int         errs;
        int         ready_errs;
        int         cyc;
        int         p;
        logic [7:0] ex;
        logic [6:0] ey;
        logic [2:0] ec;
        logic [7:0] last_x;
        logic [6:0] last_y;
        got = 0; errs = 0; ready_errs = 0; cyc = 0;
        last_x = '0; last_y = '0;
        while (got < pre + c_PIXELS && cyc < 40000) begin
            out_stall   = rnd ? ($urandom_range(0, 3) == 0) : 1'b0;
            clear_start = rnd && (cyc == 1000);
            clear_color = 3'd7;
            step();
            cyc++;
            if (vga_plot) begin
                if (got == 0 && pre > 0) begin
                    ex = 8'd10; ey = 7'd20; ec = 3'd1;
                end else if (got == 1 && pre > 1) begin
                    ex = 8'd11; ey = 7'd21; ec = 3'd2;
                end else begin
                    p  = got - pre;
                    ex = 8'(p % 160);
                    ey = 7'(p / 160);
                    ec = col;
                end
                if (vga_x !== ex || vga_y !== ey || vga_color !== ec) begin
                    if (errs == 0)
                        $display("note %s: first bad pixel #%0d got (%0d,%0d,%0d) exp (%0d,%0d,%0d)",
                                 tag, got, vga_x, vga_y, vga_color, ex, ey, ec);
                    errs++;
                end
                last_x = vga_x;
                last_y = vga_y;
                got++;
            end
            if (got < pre + c_PIXELS && req_ready) ready_errs++;
        end
        out_stall   = 1'b0;
        clear_start = 1'b0;
        check({tag, "_count"}, got, pre + c_PIXELS);
        check({tag, "_pixel_errs"}, errs, 0);
        check({tag, "_ready_during"}, ready_errs, 0);
        check({tag, "_last_x"}, {24'd0, last_x}, 159);
        check({tag, "_last_y"}, {25'd0, last_y}, 119);
        check({tag, "_ready_after"}, {31'd0, req_ready}, 1);
    endtask

    initial begin
        int plots;
        int cyc;
        n_total = 0; n_bad = 0;
        reset = 1'b1; req_valid = 1'b0; req_x = '0; req_y = '0; req_color = '0;
        clear_start = 1'b0; clear_color = '0; out_stall = 1'b0;

        // Reset state
        step(); step();
        check("rst_ready", {31'd0, req_ready}, 0);
        check("rst_plot",  {31'd0, vga_plot}, 0);
        check("rst_busy",  {31'd0, busy}, 0);
        check("rst_rerr",  {31'd0, range_err}, 0);
        reset = 1'b0;
        #1;
        check("rst_ready_after", {31'd0, req_ready}, 1);

        // T1: single plot, two-edge latency
        push_req(8'd3, 7'd5, 3'd6);
        step();
        req_valid = 1'b0;
        check("t1_plot_early", {31'd0, vga_plot}, 0);
        step();
        check("t1_plot", {31'd0, vga_plot}, 1);
        check("t1_x", {24'd0, vga_x}, 3);
        check("t1_y", {25'd0, vga_y}, 5);
        check("t1_color", {29'd0, vga_color}, 6);
        check("t1_busy_hi", {31'd0, busy}, 1);
        step();
        check("t1_plot_off", {31'd0, vga_plot}, 0);
        check("t1_busy_lo", {31'd0, busy}, 0);

        // T2: fill under stall, then drain at full rate
        out_stall = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push_req(8'(i), 7'(i + 10), 3'(i));
            check("t2_ready", {31'd0, req_ready}, (i < 4) ? 32'd1 : 32'd0);
            step();
        end
        req_valid = 1'b0;
        check("t2_stall_plot", {31'd0, vga_plot}, 0);
        check("t2_stall_busy", {31'd0, busy}, 1);
        out_stall = 1'b0;
        step();
        for (int j = 0; j < 4; j++) begin
            check("t2_plot", {31'd0, vga_plot}, 1);
            check("t2_x", {24'd0, vga_x}, j);
            check("t2_y", {25'd0, vga_y}, j + 10);
            step();
        end
        check("t2_plot_end", {31'd0, vga_plot}, 0);
        check("t2_busy_end", {31'd0, busy}, 0);

        // T3: out-of-range entry is dropped with range_err
        push_req(8'd200, 7'd5, 3'd1);
        step();
        push_req(8'd1, 7'd1, 3'd2);
        step();
        req_valid = 1'b0;
        check("t3_rerr", {31'd0, range_err}, 1);
        check("t3_noplot", {31'd0, vga_plot}, 0);
        step();
        check("t3_rerr_off", {31'd0, range_err}, 0);
        check("t3_plot", {31'd0, vga_plot}, 1);
        check("t3_x", {24'd0, vga_x}, 1);
        check("t3_color", {29'd0, vga_color}, 2);
        step();

        // T4: queued plots drain before a colour-5 clear
        out_stall = 1'b1;
        push_req(8'd10, 7'd20, 3'd1);
        step();
        push_req(8'd11, 7'd21, 3'd2);
        step();
        req_valid   = 1'b0;
        clear_start = 1'b1;
        clear_color = 3'd5;
        step();
        clear_start = 1'b0;
        check("t4_ready_drain", {31'd0, req_ready}, 0);
        run_clear("t4", 2, 3'd5, 1'b0);
        step();
        check("t4_plot_off", {31'd0, vga_plot}, 0);
        check("t4_busy_off", {31'd0, busy}, 0);

        // T5: clear under random stalls, second clear_start ignored
        clear_start = 1'b1;
        clear_color = 3'd3;
        step();
        clear_start = 1'b0;
        run_clear("t5", 0, 3'd3, 1'b1);
        plots = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (vga_plot) plots++;
        end
        check("t5_no_extra", plots, 0);
        check("t5_busy_off", {31'd0, busy}, 0);

        // T6: reset at pixel 500 of a clear
        clear_start = 1'b1;
        clear_color = 3'd2;
        step();
        clear_start = 1'b0;
        plots = 0; cyc = 0;
        while (plots < 500 && cyc < 1000) begin
            step();
            cyc++;
            if (vga_plot) plots++;
        end
        check("t6_reached_500", plots, 500);
        reset = 1'b1;
        step();
        check("t6_plot", {31'd0, vga_plot}, 0);
        check("t6_busy", {31'd0, busy}, 0);
        check("t6_ready_in_rst", {31'd0, req_ready}, 0);
        reset = 1'b0;
        #1;
        check("t6_ready_after", {31'd0, req_ready}, 1);
        plots = 0;
        for (int k = 0; k < 4; k++) begin
            step();
            if (vga_plot) plots++;
        end
        check("t6_no_plots", plots, 0);
        check("t6_idle_busy", {31'd0, busy}, 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
